hangman_game_ctrl: RTL
======================

// Module: hangman_game_ctrl
// PURPOSE
//  Parametrised game controller for the hangman display: owns the secret word, reveal mask,
//  miss counter and round timer. Sequences entry, guessing, rendering requests and end screens.
//  Talks to the keyboard decoder on the input side and to the VGA renderer via a req/done handshake.
// PARAMETERS
//  CHAR_W      8              width of one key/character code
//  MAX_LEN     16             maximum secret-word length (characters)
//  MAX_MISSES  6              misses that end the game (hangman parts)
//  TIME_LIMIT  1_500_000_000  guess-phase cycles before timeout (30 s @ 50 MHz); 0 disables timeout
//  TIMER_W     32             round-timer width; must hold TIME_LIMIT
// PORTS
//  clk          in   1             system clock
//  resetn       in   1             synchronous active-low reset
//  key_valid    in   1             one-cycle strobe: key_char holds a character
//  key_char     in   CHAR_W        character code
//  key_enter    in   1             strobe: end word entry
//  key_start    in   1             strobe: start guessing
//  key_wipe     in   1             strobe: abandon game, return to entry
//  draw_done    in   1             renderer finished current request
//  draw_req     out  1             render request, held until draw_done
//  draw_kind    out  2             0 REVEAL, 1 PART, 2 WIN, 3 LOSE
//  draw_arg     out  CHAR_W        REVEAL: guessed char; PART: miss_count (zero-extended); else 0
//  word_len     out  clog2(MAX_LEN+1)     characters stored
//  reveal_mask  out  MAX_LEN              bit i set = position i revealed
//  miss_count   out  clog2(MAX_MISSES+1)  misses so far
//  timer_run    out  1             round timer counting
//  game_over    out  1             in WIN or LOSE
//  win          out  1             in WIN
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state LOAD. All outputs 0. Word store, mask, counters and timer cleared.
//  key_wipe: in any state, highest priority. Same clearing as reset, state LOAD. draw_req drops next cycle.
//  LOAD: key_valid stores key_char at index word_len, word_len++.
//   Ignored when word_len==MAX_LEN. key_enter with word_len>0 -> READY; with word_len==0 ignored.
//   key_valid and key_enter in the same cycle: the char is stored first, then READY.
//  READY: timer cleared; key_start -> GUESS. Other keys ignored.
//  GUESS: timer_run=1, timer++ each cycle. Reaching TIME_LIMIT -> END_LOSE; timeout beats same-cycle key_valid.
//   key_valid latches guess -> CHECK. Timer holds, not cleared, outside GUESS.
//  CHECK (1 cycle): hit[i] = (word[i]==guess) & (i<word_len); new = hit & ~reveal_mask.
//   new!=0: mask |= new; DRAW, kind REVEAL, arg guess.
//   hit!=0 && new==0 (repeat letter): no change, back to GUESS, no draw.
//   hit==0: miss_count++; DRAW, kind PART, arg new miss_count.
//  DRAW: draw_req=1 from the first cycle in DRAW until draw_done is sampled high. Then draw_req=0 next cycle and:
//   mask covers all word_len positions -> END_WIN.
//   miss_count==MAX_MISSES -> END_LOSE.
//   otherwise -> GUESS.
//   draw_done outside DRAW/END request is ignored. Minimum DRAW residency is 1 cycle (draw_done may already be high).
//  END_WIN/END_LOSE: issue one request (kind WIN/LOSE, same handshake). Then hold with game_over=1, win=(END_WIN).
//   Only key_wipe or reset leaves.
//  State encoding: 3 bits, LOAD 0, READY 1, GUESS 2, CHECK 3, DRAW 4, END_WIN 5, END_LOSE 6. Unused codes -> LOAD.
//  Latency: key_valid in GUESS to draw_req high = 2 cycles (GUESS->CHECK->DRAW).
//  Counters never wrap: word_len saturates at MAX_LEN. miss_count cannot exceed MAX_MISSES.
// TESTING
//  Load "CAT", enter, start; guess 'A' -> draw_req at +2 cycles, kind 0, mask 0b010; done -> GUESS.
//  Guess 'A' again -> no draw_req, mask and miss_count unchanged, back in GUESS after CHECK.
//  Guess 'C','T' with draw_done each time -> after last done: END_WIN, WIN request, then game_over=1 win=1.
//  MAX_MISSES=2, word "Q": guess 'X','Y' -> PART args 1,2, then END_LOSE, LOSE request, win=0.
//  TIME_LIMIT=10: start, no keys -> END_LOSE after 10 GUESS cycles; key_valid on the 10th cycle ignored.
//  17 chars with MAX_LEN=16 -> word_len=16; key_wipe mid-DRAW -> draw_req 0, state LOAD, all counters 0.

Source files
------------

// File: rtl/hangman_game_ctrl.sv
// Hangman game controller: secret-word entry, guess checking, reveal/miss bookkeeping,
// round timer, and a req/done handshake toward the VGA renderer.
module hangman_game_ctrl #(
  parameter int CHAR_W     = 8,
  parameter int MAX_LEN    = 16,
  parameter int MAX_MISSES = 6,
  parameter int TIME_LIMIT = 1_500_000_000,
  parameter int TIMER_W    = 32
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             key_valid,
  input  logic [CHAR_W-1:0]                key_char,
  input  logic                             key_enter,
  input  logic                             key_start,
  input  logic                             key_wipe,
  input  logic                             draw_done,
  output logic                             draw_req,
  output logic [1:0]                       draw_kind,
  output logic [CHAR_W-1:0]                draw_arg,
  output logic [$clog2(MAX_LEN+1)-1:0]     word_len,
  output logic [MAX_LEN-1:0]               reveal_mask,
  output logic [$clog2(MAX_MISSES+1)-1:0]  miss_count,
  output logic                             timer_run,
  output logic                             game_over,
  output logic                             win
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(MAX_MISSES);
  localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(TIME_LIMIT - 1);

  localparam logic [1:0] K_REVEAL = 2'd0;
  localparam logic [1:0] K_PART   = 2'd1;
  localparam logic [1:0] K_WIN    = 2'd2;
  localparam logic [1:0] K_LOSE   = 2'd3;

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_READY    = 3'd1,
    S_GUESS    = 3'd2,
    S_CHECK    = 3'd3,
    S_DRAW     = 3'd4,
    S_END_WIN  = 3'd5,
    S_END_LOSE = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [CHAR_W-1:0]   word [MAX_LEN];
  logic [CHAR_W-1:0]   guess;
  logic [TIMER_W-1:0]  timer;
  logic                end_pending;
  logic [1:0]          kind_q;
  logic [CHAR_W-1:0]   arg_q;

  logic [MAX_LEN-1:0]  len_mask;
  logic [MAX_LEN-1:0]  hit;
  logic [MAX_LEN-1:0]  new_bits;
  logic                all_shown;
  logic                timeout;
  logic                can_store;
  logic [MISS_W-1:0]   miss_inc;

  always_comb begin
    len_mask = '0;
    hit      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < word_len);
      hit[i]      = (word[i] == guess) && len_mask[i];
    end
  end

  assign new_bits  = hit & ~reveal_mask;
  assign all_shown = &(reveal_mask | ~len_mask);
  assign timeout   = (TIME_LIMIT != 0) && (timer == LIMIT_M1);
  assign can_store = key_valid && (word_len < LEN_MAX);
  assign miss_inc  = miss_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:     if (key_enter && (word_len != '0 || can_store)) state_nxt = S_READY;
      S_READY:    if (key_start) state_nxt = S_GUESS;
      S_GUESS: begin
        if (timeout)        state_nxt = S_END_LOSE;
        else if (key_valid) state_nxt = S_CHECK;
      end
      S_CHECK:    state_nxt = (new_bits != '0 || hit == '0) ? S_DRAW : S_GUESS;
      S_DRAW: begin
        if (draw_done) begin
          if (all_shown)                  state_nxt = S_END_WIN;
          else if (miss_count == MISS_MAX) state_nxt = S_END_LOSE;
          else                            state_nxt = S_GUESS;
        end
      end
      S_END_WIN, S_END_LOSE: state_nxt = state;
      default:    state_nxt = S_LOAD;
    endcase
    if (key_wipe) state_nxt = S_LOAD;
  end

  // Game data: word store, reveal mask, counters and the pending render request.
  always_ff @(posedge clk) begin
    if (!resetn || key_wipe) begin
      for (int i = 0; i < MAX_LEN; i++) word[i] <= '0;
      word_len    <= '0;
      reveal_mask <= '0;
      miss_count  <= '0;
      timer       <= '0;
      end_pending <= 1'b0;
      kind_q      <= K_REVEAL;
      arg_q       <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (can_store) begin
            word[word_len[IDX_W-1:0]] <= key_char;
            word_len                  <= word_len + 1'b1;
          end
        end
        S_READY: timer <= '0;
        S_GUESS: begin
          if (timer != {TIMER_W{1'b1}}) timer <= timer + 1'b1;
          if (timeout) begin
            end_pending <= 1'b1;
            kind_q      <= K_LOSE;
            arg_q       <= '0;
          end
        end
        S_CHECK: begin
          if (new_bits != '0) begin
            reveal_mask <= reveal_mask | new_bits;
            kind_q      <= K_REVEAL;
            arg_q       <= guess;
          end else if (hit == '0) begin
            miss_count <= miss_inc;
            kind_q     <= K_PART;
            arg_q      <= CHAR_W'(miss_inc);
          end
        end
        S_DRAW: begin
          if (draw_done && (all_shown || miss_count == MISS_MAX)) begin
            end_pending <= 1'b1;
            kind_q      <= all_shown ? K_WIN : K_LOSE;
            arg_q       <= '0;
          end
        end
        S_END_WIN, S_END_LOSE: if (draw_done) end_pending <= 1'b0;
        default: ;
      endcase
    end
  end

  // The guess is only consumed in CHECK, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_GUESS && key_valid) guess <= key_char;
  end

  assign game_over = (state == S_END_WIN) || (state == S_END_LOSE);
  assign win       = (state == S_END_WIN);
  assign timer_run = (state == S_GUESS);
  assign draw_req  = (state == S_DRAW) || (game_over && end_pending);
  assign draw_kind = draw_req ? kind_q : K_REVEAL;
  assign draw_arg  = draw_req ? arg_q  : '0;

endmodule
